// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one AXI line-burst port between I-cache refill,
// D-cache refill and D-cache writeback. One line transaction is open at a
// time. I and D classes alternate under contention. Inside the D class,
// writeback goes ahead of refill. Each open transaction is guarded by a
// watchdog that closes it and raises a sticky error flag if it overruns.
module cache_mem_arbiter #(
   parameter int ADDR_WIDTH     = 64,
   parameter int LINE_OFFSET    = 6,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  i_ird_req,
   input  logic [ADDR_WIDTH-1:0] i_ird_addr,
   input  logic                  i_drd_req,
   input  logic [ADDR_WIDTH-1:0] i_drd_addr,
   input  logic                  i_dwr_req,
   input  logic [ADDR_WIDTH-1:0] i_dwr_addr,
   input  logic                  i_read_last_axi,
   input  logic                  i_b_resp_axi,
   input  logic                  i_timeout_clr,
   output logic                  o_start_read_axi,
   output logic                  o_start_write_axi,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [1:0]            o_grant,
   output logic                  o_ird_done,
   output logic                  o_drd_done,
   output logic                  o_dwr_done,
   output logic                  o_busy,
   output logic                  o_timeout
);

   typedef enum logic [2:0] {IDLE, RD_I, RD_D, WR_D, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{(ADDR_WIDTH - LINE_OFFSET){1'b1}}, {LINE_OFFSET{1'b0}}};
   localparam logic [CNT_WIDTH-1:0]  WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]  WD_ONE  = CNT_WIDTH'(1);

   localparam logic [1:0] G_NONE = 2'b00;
   localparam logic [1:0] G_IRD  = 2'b01;
   localparam logic [1:0] G_DRD  = 2'b10;
   localparam logic [1:0] G_DWR  = 2'b11;

   state_t               state;
   logic                 last_is_i;   // class granted most recently: 1 = I, 0 = D
   logic [CNT_WIDTH-1:0] wdog;

   logic pend_i;
   logic pend_d;
   logic pick_i;
   logic pick_d;
   logic xfer_done;

   // Class arbitration: a lone class wins, contention goes to the class not served last
   assign pend_i = i_ird_req;
   assign pend_d = i_drd_req | i_dwr_req;
   assign pick_i = pend_i & (~pend_d | ~last_is_i);
   assign pick_d = pend_d & ~pick_i;

   // Completion event relevant to the open transaction; the other channel is ignored
   assign xfer_done = ((state == RD_I || state == RD_D) && i_read_last_axi) ||
                      ((state == WR_D) && i_b_resp_axi);

   // Transaction sequencer with registered outputs, watchdog and sticky timeout flag
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state             <= IDLE;
         last_is_i         <= 1'b0;
         wdog              <= '0;
         o_start_read_axi  <= 1'b0;
         o_start_write_axi <= 1'b0;
         o_addr            <= '0;
         o_grant           <= G_NONE;
         o_ird_done        <= 1'b0;
         o_drd_done        <= 1'b0;
         o_dwr_done        <= 1'b0;
         o_busy            <= 1'b0;
         o_timeout         <= 1'b0;
      end else begin
         // A clear is overridden below when a timeout fires on the same edge
         if (i_timeout_clr)
            o_timeout <= 1'b0;

         case (state)
            IDLE: begin
               if (pick_i) begin
                  state            <= RD_I;
                  last_is_i        <= 1'b1;
                  wdog             <= '0;
                  o_addr           <= i_ird_addr & LINE_MASK;
                  o_grant          <= G_IRD;
                  o_start_read_axi <= 1'b1;
                  o_busy           <= 1'b1;
               end else if (pick_d) begin
                  last_is_i <= 1'b0;
                  wdog      <= '0;
                  o_busy    <= 1'b1;
                  if (i_dwr_req) begin
                     state             <= WR_D;
                     o_addr            <= i_dwr_addr & LINE_MASK;
                     o_grant           <= G_DWR;
                     o_start_write_axi <= 1'b1;
                  end else begin
                     state            <= RD_D;
                     o_addr           <= i_drd_addr & LINE_MASK;
                     o_grant          <= G_DRD;
                     o_start_read_axi <= 1'b1;
                  end
               end
            end

            RD_I, RD_D, WR_D: begin
               wdog <= wdog + WD_ONE;
               if (xfer_done) begin
                  state             <= DONE;
                  o_start_read_axi  <= 1'b0;
                  o_start_write_axi <= 1'b0;
                  o_ird_done        <= (state == RD_I);
                  o_drd_done        <= (state == RD_D);
                  o_dwr_done        <= (state == WR_D);
               end else if (wdog == WD_LAST) begin
                  state             <= IDLE;
                  o_start_read_axi  <= 1'b0;
                  o_start_write_axi <= 1'b0;
                  o_grant           <= G_NONE;
                  o_busy            <= 1'b0;
                  o_timeout         <= 1'b1;
               end
            end

            DONE: begin
               state      <= IDLE;
               o_grant    <= G_NONE;
               o_busy     <= 1'b0;
               o_ird_done <= 1'b0;
               o_drd_done <= 1'b0;
               o_dwr_done <= 1'b0;
            end

            default: begin
               state             <= IDLE;
               o_start_read_axi  <= 1'b0;
               o_start_write_axi <= 1'b0;
               o_grant           <= G_NONE;
               o_busy            <= 1'b0;
               o_ird_done        <= 1'b0;
               o_drd_done        <= 1'b0;
               o_dwr_done        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level arbitration model.
module tb_cache_mem_arbiter;

   localparam int AW = 64;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          arst = 1'b1;
   logic          ird_req = 1'b0, drd_req = 1'b0, dwr_req = 1'b0;
   logic [AW-1:0] ird_addr = '0, drd_addr = '0, dwr_addr = '0;
   logic          read_last = 1'b0, b_resp = 1'b0, tmo_clr = 1'b0;
   logic          start_rd, start_wr, ird_done, drd_done, dwr_done, busy, tmo;
   logic [AW-1:0] addr;
   logic [1:0]    grant;

   int tests = 0;
   int fails = 0;

   cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_OFFSET(6), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .arst(arst),
      .i_ird_req(ird_req), .i_ird_addr(ird_addr),
      .i_drd_req(drd_req), .i_drd_addr(drd_addr),
      .i_dwr_req(dwr_req), .i_dwr_addr(dwr_addr),
      .i_read_last_axi(read_last), .i_b_resp_axi(b_resp), .i_timeout_clr(tmo_clr),
      .o_start_read_axi(start_rd), .o_start_write_axi(start_wr),
      .o_addr(addr), .o_grant(grant),
      .o_ird_done(ird_done), .o_drd_done(drd_done), .o_dwr_done(dwr_done),
      .o_busy(busy), .o_timeout(tmo)
   );

   always #5 clk = ~clk;

   // Packed view: grant[8:7] rd[6] wr[5] busy[4] ird_done[3] drd_done[2] dwr_done[1] timeout[0]
   function automatic logic [8:0] st();
      return {grant, start_rd, start_wr, busy, ird_done, drd_done, dwr_done, tmo};
   endfunction

   // Expected status while a transaction with grant g is open
   function automatic logic [8:0] busy_exp(input logic [1:0] g);
      return {g, (g != 2'b11), (g == 2'b11), 1'b1, 3'b000, 1'b0};
   endfunction

   // Expected status during the completion cycle of grant g
   function automatic logic [8:0] done_exp(input logic [1:0] g);
      return {g, 1'b0, 1'b0, 1'b1, (g == 2'b01), (g == 2'b10), (g == 2'b11), 1'b0};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      tests++;
      if (st() !== 9'b0 || addr !== '0) begin
         fails++;
         $display("FAIL reset_state: status=%b addr=%h want 0", st(), addr);
      end
      cyc();
      arst = 1'b0;
      cyc();
      tests++;
      if (st() !== 9'b0) begin
         fails++;
         $display("FAIL reset_release: status=%b want 0", st());
      end
   endtask

   task automatic test_single_i();
      ird_req = 1'b1; ird_addr = 64'h1234;
      cyc();
      tests++;
      if (st() !== busy_exp(2'b01) || addr !== 64'h1200) begin
         fails++;
         $display("FAIL single_i_grant: status=%b addr=%h want %b 1200", st(), addr, busy_exp(2'b01));
      end
      for (int k = 2; k <= 7; k++) begin
         cyc();
         tests++;
         if (st() !== busy_exp(2'b01)) begin
            fails++;
            $display("FAIL single_i_hold: cycle %0d status=%b want %b", k, st(), busy_exp(2'b01));
         end
      end
      read_last = 1'b1;
      cyc();
      tests++;
      if (st() !== done_exp(2'b01)) begin
         fails++;
         $display("FAIL single_i_done: status=%b want %b", st(), done_exp(2'b01));
      end
      ird_req = 1'b0; read_last = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cyc();
         tests++;
         if (st() !== 9'b0) begin
            fails++;
            $display("FAIL single_i_idle: status=%b want 0", st());
         end
      end
   endtask

   task automatic test_d_priority();
      drd_req = 1'b1; drd_addr = 64'h80;
      dwr_req = 1'b1; dwr_addr = 64'h4C0;
      cyc();
      tests++;
      if (st() !== busy_exp(2'b11) || addr !== 64'h4C0) begin
         fails++;
         $display("FAIL d_wr_first: status=%b addr=%h want %b 4c0", st(), addr, busy_exp(2'b11));
      end
      cyc();
      cyc();
      b_resp = 1'b1;
      cyc();
      tests++;
      if (st() !== done_exp(2'b11)) begin
         fails++;
         $display("FAIL d_wr_done: status=%b want %b", st(), done_exp(2'b11));
      end
      dwr_req = 1'b0; b_resp = 1'b0;
      cyc();
      tests++;
      if (st() !== 9'b0) begin
         fails++;
         $display("FAIL d_gap_idle: status=%b want 0", st());
      end
      cyc();
      tests++;
      if (st() !== busy_exp(2'b10) || addr !== 64'h80) begin
         fails++;
         $display("FAIL d_rd_second: status=%b addr=%h want %b 80", st(), addr, busy_exp(2'b10));
      end
      read_last = 1'b1;
      cyc();
      drd_req = 1'b0; read_last = 1'b0;
      cyc();
   endtask

   task automatic test_round_robin();
      logic [1:0] order [4];
      order[0] = 2'b01; order[1] = 2'b11; order[2] = 2'b01; order[3] = 2'b10;
      ird_req = 1'b1; drd_req = 1'b1; dwr_req = 1'b1;
      ird_addr = 64'h1000; drd_addr = 64'h2000; dwr_addr = 64'h3000;
      for (int n = 0; n < 4; n++) begin
         cyc();
         tests++;
         if (grant !== order[n] || st() !== busy_exp(order[n])) begin
            fails++;
            $display("FAIL rr_order[%0d]: grant=%b status=%b want grant %b", n, grant, st(), order[n]);
         end
         if (order[n] == 2'b11) b_resp = 1'b1; else read_last = 1'b1;
         cyc();
         tests++;
         if (st() !== done_exp(order[n])) begin
            fails++;
            $display("FAIL rr_done[%0d]: status=%b want %b", n, st(), done_exp(order[n]));
         end
         b_resp = 1'b0; read_last = 1'b0;
         case (order[n])
            2'b01:   ird_req = 1'b0;
            2'b10:   drd_req = 1'b0;
            default: dwr_req = 1'b0;
         endcase
         cyc();
         if (n == 0) ird_req = 1'b1;
      end
   endtask

   task automatic test_timeout();
      drd_req = 1'b1; drd_addr = 64'h7777;
      cyc();
      for (int k = 2; k <= TO; k++) begin
         cyc();
         tests++;
         if (st() !== busy_exp(2'b10)) begin
            fails++;
            $display("FAIL tmo_busy: cycle %0d status=%b want %b", k, st(), busy_exp(2'b10));
         end
      end
      drd_req = 1'b0;
      cyc();
      tests++;
      if (st() !== 9'b000000001) begin
         fails++;
         $display("FAIL tmo_fire: status=%b want 000000001", st());
      end
      cyc();
      tests++;
      if (tmo !== 1'b1) begin
         fails++;
         $display("FAIL tmo_sticky: timeout=%b want 1", tmo);
      end
      tmo_clr = 1'b1;
      cyc();
      tmo_clr = 1'b0;
      tests++;
      if (tmo !== 1'b0) begin
         fails++;
         $display("FAIL tmo_clear: timeout=%b want 0", tmo);
      end
   endtask

   task automatic test_expiry_race();
      ird_req = 1'b1; ird_addr = 64'hABC0;
      cyc();
      for (int k = 2; k <= TO; k++) cyc();
      read_last = 1'b1;
      cyc();
      tests++;
      if (st() !== done_exp(2'b01)) begin
         fails++;
         $display("FAIL race_done_wins: status=%b want %b", st(), done_exp(2'b01));
      end
      ird_req = 1'b0; read_last = 1'b0;
      cyc();
      tests++;
      if (st() !== 9'b0) begin
         fails++;
         $display("FAIL race_idle: status=%b want 0", st());
      end
   endtask

   task automatic test_set_wins();
      drd_req = 1'b1; drd_addr = 64'h5500;
      cyc();
      for (int k = 2; k <= TO; k++) cyc();
      drd_req = 1'b0; tmo_clr = 1'b1;
      cyc();
      tmo_clr = 1'b0;
      tests++;
      if (tmo !== 1'b1) begin
         fails++;
         $display("FAIL set_over_clear: timeout=%b want 1", tmo);
      end
      tmo_clr = 1'b1;
      cyc();
      tmo_clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      dwr_req = 1'b1; dwr_addr = 64'h9900;
      cyc();
      cyc();
      #2 arst = 1'b1;
      #1;
      tests++;
      if (st() !== 9'b0 || addr !== '0) begin
         fails++;
         $display("FAIL async_reset: status=%b addr=%h want 0", st(), addr);
      end
      cyc();
      tests++;
      if (st() !== 9'b0) begin
         fails++;
         $display("FAIL reset_no_done: status=%b want 0", st());
      end
      dwr_req = 1'b0; ird_req = 1'b1; drd_req = 1'b1;
      ird_addr = 64'h40; drd_addr = 64'hC0;
      arst = 1'b0;
      cyc();
      tests++;
      if (st() !== busy_exp(2'b01) || addr !== 64'h40) begin
         fails++;
         $display("FAIL post_reset_i_first: status=%b addr=%h want %b 40", st(), addr, busy_exp(2'b01));
      end
      read_last = 1'b1;
      cyc();
      ird_req = 1'b0; read_last = 1'b0;
      cyc();
      cyc();
      tests++;
      if (st() !== busy_exp(2'b10) || addr !== 64'hC0) begin
         fails++;
         $display("FAIL post_reset_d_next: status=%b addr=%h want %b c0", st(), addr, busy_exp(2'b10));
      end
      read_last = 1'b1;
      cyc();
      drd_req = 1'b0; read_last = 1'b0;
      cyc();
   endtask

   task automatic test_spurious();
      ird_req = 1'b1; ird_addr = 64'h2222;
      cyc();
      b_resp = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         tests++;
         if (st() !== busy_exp(2'b01)) begin
            fails++;
            $display("FAIL spurious_bresp: status=%b want %b", st(), busy_exp(2'b01));
         end
      end
      b_resp = 1'b0; read_last = 1'b1;
      cyc();
      ird_req = 1'b0;
      cyc();
      b_resp = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         tests++;
         if (st() !== 9'b0) begin
            fails++;
            $display("FAIL spurious_idle: status=%b want 0", st());
         end
      end
      read_last = 1'b0; b_resp = 1'b0;
   endtask

   task automatic test_random();
      logic          last_i;
      logic [2:0]    r;
      logic [1:0]    g;
      logic [AW-1:0] want_addr;
      int            lat, lim;
      arst = 1'b1;
      cyc();
      arst = 1'b0;
      last_i = 1'b0;
      for (int it = 0; it < 40; it++) begin
         r = 3'($urandom_range(1, 7));
         ird_req = r[0]; drd_req = r[1]; dwr_req = r[2];
         ird_addr = {$urandom, $urandom};
         drd_addr = {$urandom, $urandom};
         dwr_addr = {$urandom, $urandom};
         if (ird_req && (!(drd_req || dwr_req) || !last_i)) begin
            g = 2'b01; want_addr = ird_addr; last_i = 1'b1;
         end else if (dwr_req) begin
            g = 2'b11; want_addr = dwr_addr; last_i = 1'b0;
         end else begin
            g = 2'b10; want_addr = drd_addr; last_i = 1'b0;
         end
         want_addr[5:0] = 6'd0;
         lat = $urandom_range(1, 20);
         lim = (lat < TO) ? lat : TO;
         cyc();
         for (int k = 1; k <= lim; k++) begin
            if (k > 1) cyc();
            tests++;
            if (st() !== busy_exp(g) || addr !== want_addr) begin
               fails++;
               $display("FAIL rand_busy it%0d k%0d: status=%b addr=%h want %b %h",
                        it, k, st(), addr, busy_exp(g), want_addr);
            end
            ird_addr = {$urandom, $urandom};
            drd_addr = {$urandom, $urandom};
            dwr_addr = {$urandom, $urandom};
            if (g == 2'b11) begin
               read_last = 1'($urandom);
               b_resp    = (k == lat);
            end else begin
               b_resp    = 1'($urandom);
               read_last = (k == lat);
            end
            if (k == TO && lat > TO) begin
               ird_req = 1'b0; drd_req = 1'b0; dwr_req = 1'b0;
            end
         end
         cyc();
         read_last = 1'b0; b_resp = 1'b0;
         if (lat <= TO) begin
            tests++;
            if (st() !== done_exp(g)) begin
               fails++;
               $display("FAIL rand_done it%0d: status=%b want %b", it, st(), done_exp(g));
            end
            ird_req = 1'b0; drd_req = 1'b0; dwr_req = 1'b0;
            cyc();
            tests++;
            if (st() !== 9'b0) begin
               fails++;
               $display("FAIL rand_idle it%0d: status=%b want 0", it, st());
            end
         end else begin
            tests++;
            if (st() !== 9'b000000001) begin
               fails++;
               $display("FAIL rand_timeout it%0d: status=%b want 000000001", it, st());
            end
            tmo_clr = 1'b1;
            cyc();
            tmo_clr = 1'b0;
            tests++;
            if (st() !== 9'b0) begin
               fails++;
               $display("FAIL rand_clear it%0d: status=%b want 0", it, st());
            end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_single_i();
      test_d_priority();
      test_round_robin();
      test_timeout();
      test_expiry_race();
      test_set_wins();
      test_reset_mid();
      test_spurious();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single 512-bit AXI burst port between three requesters: I-cache line refill, D-cache line refill and D-cache dirty writeback.
- Sits between the control unit's cache-miss sequencing and the AXI master.
- Serializes line transactions, drives the start/address signals and returns per-requester completion pulses.
- Provides a grant code for the external data-routing muxes and watchdogs each transaction with a timeout.

Parameters:
ADDR_WIDTH, 64, request/AXI address width
LINE_OFFSET, 6, log2 of line size in bytes (512-bit line)
TIMEOUT_CYCLES, 1024, max cycles a granted transaction may stay open
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), watchdog counter width

Ports:
clk  in  1  clock, all state on rising edge
arst  in  1  asynchronous reset, active-high
i_ird_req  in  1  I-cache refill request, level, held until done
i_ird_addr  in  ADDR_WIDTH  I-cache miss address
i_drd_req  in  1  D-cache refill request, level
i_drd_addr  in  ADDR_WIDTH  D-cache miss address
i_dwr_req  in  1  D-cache writeback request, level
i_dwr_addr  in  ADDR_WIDTH  victim line address
i_read_last_axi  in  1  last beat of read burst accepted
i_b_resp_axi  in  1  write response received
i_timeout_clr  in  1  clears sticky timeout flag
o_start_read_axi  out  1  read burst active, level
o_start_write_axi  out  1  write burst active, level
o_addr  out  ADDR_WIDTH  line-aligned address of granted transaction
o_grant  out  2  00 none, 01 I read, 10 D read, 11 D write
o_ird_done  out  1  1-cycle completion pulse
o_drd_done  out  1  1-cycle completion pulse
o_dwr_done  out  1  1-cycle completion pulse
o_busy  out  1  state != IDLE
o_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (async, arst=1): state IDLE; all outputs 0; o_addr 0; watchdog 0; last_class=D, so I has priority at the first contention. Reset mid-transaction aborts immediately, and no done pulse is issued.
- States: IDLE, RD_I, RD_D, WR_D, DONE.
- IDLE: arbitration is evaluated combinationally from the req inputs. The chosen transaction is registered on the next edge. The requester's address is latched with bits [LINE_OFFSET-1:0] forced to 0. o_grant and o_start_* are registered and valid from the first cycle of the busy state.
- Class arbitration: I class = i_ird_req; D class = i_drd_req | i_dwr_req.
  - Only one class pending: grant that class.
  - Both pending: grant the class opposite to last_class (round-robin).
  - last_class updates at grant.
- Within the D class: writeback strictly before refill when both are asserted.
- RD_I / RD_D: o_start_read_axi=1. On an edge with i_read_last_axi=1, go to DONE with the matching done pulse high during DONE. i_b_resp_axi is ignored.
- WR_D: o_start_write_axi=1. On an edge with i_b_resp_axi=1, go to DONE with o_dwr_done high. i_read_last_axi is ignored.
- DONE: lasts exactly 1 cycle. The done pulse is high, o_grant holds its value, o_start_* are 0, o_busy=1, and no arbitration occurs. Next state is IDLE.
  - Requesters must drop req during DONE. A req still high in IDLE is treated as a new request.
- Minimum spacing between back-to-back transactions: busy state, DONE, IDLE, then the next grant. That is 2 idle cycles of o_start_*.
- Completion and address inputs in IDLE/DONE are ignored. Address inputs are not re-sampled while busy.
- Watchdog:
  - Cleared on entry to any busy state; increments each cycle in RD_I/RD_D/WR_D.
  - When the count reaches TIMEOUT_CYCLES without completion, go to IDLE without a done pulse, set o_timeout=1 and drop o_start_*. last_class is unchanged.
  - Completion arriving in the same cycle as expiry wins: normal DONE, no timeout.
- o_timeout clears on i_timeout_clr=1. If a new timeout and a clear occur in the same cycle, set wins.
- o_grant=00 in IDLE only.

Test Plan:
- Single I refill, i_ird_addr=0x0000_1234 -> next cycle o_grant=01, o_start_read_axi=1, o_addr=0x0000_1200. i_read_last_axi at cycle 8 -> o_ird_done pulses exactly 1 cycle, then IDLE, o_grant=00.
- i_drd_req and i_dwr_req together (addrs 0x80, 0x4C0) -> WR_D first, o_addr=0x4C0, o_start_write_axi=1. After i_b_resp_axi -> o_dwr_done. RD_D is granted 2 cycles later with o_addr=0x80.
- All three requests held continuously from reset -> grant order I, D(wr), I, D(rd), matching alternation by class.
- With TIMEOUT_CYCLES=16, grant RD_D with no i_read_last_axi -> after 16 busy cycles o_timeout=1, no done pulse, IDLE. i_timeout_clr clears it.
- arst asserted mid-WR_D -> all outputs 0 asynchronously, no o_dwr_done. After release, a pending I and D contention grants I first.
- Spurious i_b_resp_axi during RD_I and i_read_last_axi during IDLE -> no state change, no done pulse.
